// File: rtl/nt_monitor_pkg.sv
// Shared definitions for the Nt-node observation monitors.
// Holds the monitor state encoding and the MISR seed / feedback tap mask.
package nt_monitor_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMonitor = 2'd1,
    StAlarm   = 2'd2
  } nt_state_e;

  localparam logic [15:0] MisrSeed = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] MisrTaps = 16'hB400;

endpackage

// File: rtl/nt_misr16.sv
// 16-bit serial-input MISR with enable and synchronous active-low reset to a seed.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset, loads Seed
//   en_i   - absorb data_i this cycle
//   data_i - serial input bit
//   sig_o  - current signature
module nt_misr16
  import nt_monitor_pkg::*;
#(
  parameter logic [15:0] Seed = MisrSeed,
  parameter logic [15:0] Taps = MisrTaps
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (en_i) begin
      sig_d = {sig_q[14:0], (^(sig_q & Taps)) ^ data_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sig_q <= Seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/nt_trigger_monitor.sv
// Rare-value rate monitor for a single Nt-node output.
// Tracks rare-value occurrences in a sliding window, raises a sticky alarm when the
// windowed count reaches THRESH on a full window, counts alarm entries and compacts
// the sampled stream into a MISR signature.
// Ports:
//   I1470_clk     - clock, rising edge
//   I1477_rst     - synchronous active-low reset
//   node_in       - observed node value
//   sample_en     - take node_in this cycle
//   clear         - soft clear of window, count, alarm (signature/event count kept)
//   alarm         - sticky alarm
//   match_cnt     - rare-value count in window
//   win_full      - window holds WIN samples
//   alarm_evt_cnt - saturating count of alarm entries
//   signature     - MISR state
module nt_trigger_monitor
  import nt_monitor_pkg::*;
#(
  parameter int unsigned WIN      = 8,
  parameter int unsigned THRESH   = 5,
  parameter logic        RARE_VAL = 1'b0,
  parameter int unsigned EVT_W    = 8,
  localparam int unsigned CW      = $clog2(WIN + 1)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             node_in,
  input  logic             sample_en,
  input  logic             clear,
  output logic             alarm,
  output logic [CW-1:0]    match_cnt,
  output logic             win_full,
  output logic [EVT_W-1:0] alarm_evt_cnt,
  output logic [15:0]      signature
);

  localparam logic [CW-1:0] FullC   = CW'(WIN);
  localparam logic [CW-1:0] ThreshC = CW'(THRESH);

  nt_state_e        state_q, state_d;
  logic [WIN-1:0]   win_q, win_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             alarm_q, alarm_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             hit;
  logic             drop;

  assign hit  = (node_in == RARE_VAL);
  // The oldest bit only leaves the count once the window is full.
  assign drop = full_q & win_q[WIN-1];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    evt_d   = evt_q;
    if (clear) begin
      // Clear takes priority over a concurrent sample; the MISR still absorbs it.
      state_d = StIdle;
      win_d   = '0;
      fill_d  = '0;
      cnt_d   = '0;
      alarm_d = 1'b0;
    end else if (sample_en) begin
      win_d = {win_q[WIN-2:0], hit};
      if (!full_q) begin
        fill_d = fill_q + 1'b1;
      end
      if (hit && !drop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!hit && drop) begin
        cnt_d = cnt_q - 1'b1;
      end
      case (state_q)
        StIdle: state_d = StMonitor;
        StMonitor: begin
          if ((fill_d == FullC) && (cnt_d >= ThreshC)) begin
            state_d = StAlarm;
            alarm_d = 1'b1;
            if (evt_q != '1) begin
              evt_d = evt_q + 1'b1;
            end
          end
        end
        StAlarm: state_d = StAlarm;
        default: state_d = StIdle;
      endcase
    end
    full_d = (fill_d == FullC);
  end

  always_ff @(posedge I1470_clk) begin
    if (!I1477_rst) begin
      state_q <= StIdle;
      win_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      alarm_q <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      alarm_q <= alarm_d;
      evt_q   <= evt_d;
    end
  end

  nt_misr16 #(
    .Seed(MisrSeed),
    .Taps(MisrTaps)
  ) u_misr (
    .clk_i (I1470_clk),
    .rst_ni(I1477_rst),
    .en_i  (sample_en),
    .data_i(node_in),
    .sig_o (signature)
  );

  assign alarm         = alarm_q;
  assign match_cnt     = cnt_q;
  assign win_full      = full_q;
  assign alarm_evt_cnt = evt_q;

endmodule

// File: tb/tb_nt_trigger_monitor.sv
// Self-checking bench for nt_trigger_monitor: directed scenarios plus random stimulus,
// all compared against a queue-based behavioural model.
module tb_nt_trigger_monitor;

  localparam int unsigned WIN    = 8;
  localparam int unsigned THRESH = 5;
  localparam logic        RARE   = 1'b0;
  localparam int unsigned EVT_W  = 8;
  localparam int unsigned CW     = $clog2(WIN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             node_in;
  logic             sample_en;
  logic             clear;
  logic             alarm;
  logic [CW-1:0]    match_cnt;
  logic             win_full;
  logic [EVT_W-1:0] alarm_evt_cnt;
  logic [15:0]      signature;

  always #5 clk = ~clk;

  nt_trigger_monitor #(
    .WIN     (WIN),
    .THRESH  (THRESH),
    .RARE_VAL(RARE),
    .EVT_W   (EVT_W)
  ) dut (
    .I1470_clk    (clk),
    .I1477_rst    (rst_n),
    .node_in      (node_in),
    .sample_en    (sample_en),
    .clear        (clear),
    .alarm        (alarm),
    .match_cnt    (match_cnt),
    .win_full     (win_full),
    .alarm_evt_cnt(alarm_evt_cnt),
    .signature    (signature)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the window is just the list of the last WIN match bits.
  bit          m_q[$];
  bit          m_alarm;
  int unsigned m_evt;
  logic [15:0] m_sig;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_sum();
    int unsigned s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_alarm = 1'b0;
    m_evt   = 0;
    m_sig   = 16'hACE1;
  endtask

  task automatic model_step(input bit r, input bit en, input bit nin, input bit clr);
    if (!r) begin
      model_reset();
    end else begin
      if (en) begin
        m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10] ^ nin};
      end
      if (clr) begin
        m_q.delete();
        m_alarm = 1'b0;
      end else if (en) begin
        m_q.push_back(nin == RARE);
        if (m_q.size() > WIN) void'(m_q.pop_front());
        if (!m_alarm && m_q.size() == WIN && m_sum() >= THRESH) begin
          m_alarm = 1'b1;
          if (m_evt < (1 << EVT_W) - 1) m_evt++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("alarm", 32'(alarm), 32'(m_alarm));
    check_eq("match_cnt", 32'(match_cnt), m_sum());
    check_eq("win_full", 32'(win_full), 32'(m_q.size() == WIN));
    check_eq("alarm_evt_cnt", 32'(alarm_evt_cnt), m_evt);
    check_eq("signature", 32'(signature), 32'(m_sig));
  endtask

  task automatic step(input bit r, input bit en, input bit nin, input bit clr);
    rst_n     = r;
    sample_en = en;
    node_in   = nin;
    clear     = clr;
    @(posedge clk);
    model_step(r, en, nin, clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    node_in   = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    model_reset();

    // Reset, then idle with node_in toggling: nothing moves.
    do_reset();
    check_eq("rst_sig", 32'(signature), 32'h0000ACE1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, i[0], 1'b0);

    // Single sample of a non-rare value.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("single_sig", 32'(signature), 32'h000059C2);
    check_eq("single_cnt", 32'(match_cnt), 32'd0);

    // Early-count gating: 5 rare samples before the window is full.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("early_cnt", 32'(match_cnt), 32'd5);
    check_eq("early_alarm", 32'(alarm), 32'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("early_alarm7", 32'(alarm), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("full_alarm", 32'(alarm), 32'd1);
    check_eq("full_evt", 32'(alarm_evt_cnt), 32'd1);

    // Sliding window: 8 ones, 5 zeros, then 8 ones with alarm held.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("slide_cnt", 32'(match_cnt), 32'(i + 1));
    end
    check_eq("slide_noalarm", 32'(alarm), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("slide_alarm", 32'(alarm), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("slide_sticky", 32'(alarm), 32'd1);
    check_eq("slide_decay", 32'(match_cnt), 32'd0);

    // Clear with sample in ALARM.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("clr_alarm", 32'(alarm), 32'd0);
    check_eq("clr_full", 32'(win_full), 32'd0);
    check_eq("clr_evt", 32'(alarm_evt_cnt), 32'd1);

    // Saturation of the event counter.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check_eq("sat_evt", 32'(alarm_evt_cnt), 32'd255);

    // Mid-window reset overrides clear and sample.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("mid_rst_sig", 32'(signature), 32'h0000ACE1);
    check_eq("mid_rst_evt", 32'(alarm_evt_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) != 0),
           ($urandom_range(99) < 75),
           ($urandom_range(99) >= 45),
           ($urandom_range(99) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
